// File: rtl/exponent_aligner_if.sv
// Operand/result handshake bundle for the exponent aligner.
// The slave side is the aligner; the master side drives operands and consumes results.
interface exponent_aligner_if #(
    parameter int unsigned EXP_W  = 8,
    parameter int unsigned MANT_W = 24
);
    logic                  in_valid;
    logic                  in_ready;
    logic [EXP_W-1:0]      exp_a;
    logic [MANT_W-1:0]     mant_a;
    logic [EXP_W-1:0]      exp_b;
    logic [MANT_W-1:0]     mant_b;
    logic                  out_valid;
    logic                  out_ready;
    logic [EXP_W-1:0]      exp_out;
    logic [MANT_W-1:0]     mant_big;
    logic [MANT_W+2:0]     mant_small;
    logic                  swapped;

    modport master (
        output in_valid, exp_a, mant_a, exp_b, mant_b, out_ready,
        input  in_ready, out_valid, exp_out, mant_big, mant_small, swapped
    );

    modport slave (
        input  in_valid, exp_a, mant_a, exp_b, mant_b, out_ready,
        output in_ready, out_valid, exp_out, mant_big, mant_small, swapped
    );
endinterface

// File: rtl/exponent_aligner.sv
// Pre-add alignment stage: orders two operands by magnitude and iteratively
// right-shifts the smaller mantissa by the exponent difference, folding the
// shifted-out bits into a guard/round/sticky tail.
// The interface instance must be parameterised with the same EXP_W/MANT_W.
module exponent_aligner #(
    parameter int unsigned EXP_W      = 8,
    parameter int unsigned MANT_W     = 24,
    parameter int unsigned SHIFT_STEP = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    exponent_aligner_if.slave  bus
);
    localparam int unsigned SmallW = MANT_W + 3;

    typedef enum logic [1:0] {StIdle, StCompare, StShift, StDone} state_e;

    state_e              r_state;
    state_e              w_state_nxt;

    logic [EXP_W-1:0]    r_exp_a,      w_exp_a_nxt;
    logic [MANT_W-1:0]   r_mant_a,     w_mant_a_nxt;
    logic [EXP_W-1:0]    r_exp_b,      w_exp_b_nxt;
    logic [MANT_W-1:0]   r_mant_b,     w_mant_b_nxt;
    logic [EXP_W-1:0]    r_exp_out,    w_exp_out_nxt;
    logic [MANT_W-1:0]   r_mant_big,   w_mant_big_nxt;
    logic [SmallW-1:0]   r_small,      w_small_nxt;
    logic                r_swapped,    w_swapped_nxt;
    logic [EXP_W-1:0]    r_rem,        w_rem_nxt;

    logic                w_a_big;
    logic [EXP_W-1:0]    w_diff;
    logic [MANT_W-1:0]   w_mant_sm_in;
    logic [EXP_W-1:0]    w_k;
    logic [SmallW-1:0]   w_mask;
    logic                w_lost;
    logic [SmallW-1:0]   w_shifted;

    // Ties go to A so that swapped only flags a strictly larger B.
    assign w_a_big      = (r_exp_a > r_exp_b) ||
                          ((r_exp_a == r_exp_b) && (r_mant_a >= r_mant_b));
    assign w_diff       = w_a_big ? (r_exp_a - r_exp_b) : (r_exp_b - r_exp_a);
    assign w_mant_sm_in = w_a_big ? r_mant_b : r_mant_a;

    // One shift step: at most SHIFT_STEP bits, lost bits OR'd into the sticky.
    always_comb begin
        w_k       = (r_rem < EXP_W'(SHIFT_STEP)) ? r_rem : EXP_W'(SHIFT_STEP);
        w_mask    = ~({SmallW{1'b1}} << w_k);
        w_lost    = |(r_small & w_mask);
        w_shifted = r_small >> w_k;
        w_shifted[0] = w_shifted[0] | w_lost;
    end

    // Next-state and datapath update for the IDLE/COMPARE/SHIFT/DONE sequence.
    always_comb begin
        w_state_nxt    = r_state;
        w_exp_a_nxt    = r_exp_a;
        w_mant_a_nxt   = r_mant_a;
        w_exp_b_nxt    = r_exp_b;
        w_mant_b_nxt   = r_mant_b;
        w_exp_out_nxt  = r_exp_out;
        w_mant_big_nxt = r_mant_big;
        w_small_nxt    = r_small;
        w_swapped_nxt  = r_swapped;
        w_rem_nxt      = r_rem;

        case (r_state)
            StIdle: begin
                if (bus.in_valid) begin
                    w_exp_a_nxt  = bus.exp_a;
                    w_mant_a_nxt = bus.mant_a;
                    w_exp_b_nxt  = bus.exp_b;
                    w_mant_b_nxt = bus.mant_b;
                    w_state_nxt  = StCompare;
                end
            end
            StCompare: begin
                w_exp_out_nxt  = w_a_big ? r_exp_a : r_exp_b;
                w_mant_big_nxt = w_a_big ? r_mant_a : r_mant_b;
                w_swapped_nxt  = ~w_a_big;
                w_small_nxt    = {w_mant_sm_in, 3'b000};
                w_rem_nxt      = w_diff;
                if (w_diff == '0) begin
                    w_state_nxt = StDone;
                end else if (32'(w_diff) >= SmallW) begin
                    // Everything falls into the sticky bit; skip the iteration.
                    w_small_nxt = {{(SmallW-1){1'b0}}, |w_mant_sm_in};
                    w_rem_nxt   = '0;
                    w_state_nxt = StDone;
                end else begin
                    w_state_nxt = StShift;
                end
            end
            StShift: begin
                w_small_nxt = w_shifted;
                w_rem_nxt   = r_rem - w_k;
                if (r_rem == w_k) begin
                    w_state_nxt = StDone;
                end
            end
            StDone: begin
                if (bus.out_ready) begin
                    w_state_nxt = StIdle;
                end
            end
            default: begin
                w_state_nxt = StIdle;
            end
        endcase
    end

    // State and datapath registers; reset drops any operation in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= StIdle;
            r_exp_a    <= '0;
            r_mant_a   <= '0;
            r_exp_b    <= '0;
            r_mant_b   <= '0;
            r_exp_out  <= '0;
            r_mant_big <= '0;
            r_small    <= '0;
            r_swapped  <= 1'b0;
            r_rem      <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_exp_a    <= w_exp_a_nxt;
            r_mant_a   <= w_mant_a_nxt;
            r_exp_b    <= w_exp_b_nxt;
            r_mant_b   <= w_mant_b_nxt;
            r_exp_out  <= w_exp_out_nxt;
            r_mant_big <= w_mant_big_nxt;
            r_small    <= w_small_nxt;
            r_swapped  <= w_swapped_nxt;
            r_rem      <= w_rem_nxt;
        end
    end

    assign bus.in_ready   = (r_state == StIdle);
    assign bus.out_valid  = (r_state == StDone);
    assign bus.exp_out    = r_exp_out;
    assign bus.mant_big   = r_mant_big;
    assign bus.mant_small = r_small;
    assign bus.swapped    = r_swapped;
endmodule

// File: tb/tb_exponent_aligner.sv
// Self-checking bench for exponent_aligner: directed operand pairs, a
// magnitude/alignment model in plain arithmetic, and a per-cycle result monitor.
module tb_exponent_aligner;
    logic clk;
    logic rst_n;

    exponent_aligner_if #(.EXP_W(8), .MANT_W(24)) bus ();

    exponent_aligner #(.EXP_W(8), .MANT_W(24), .SHIFT_STEP(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic [7:0]  e;
        logic [23:0] mb;
        logic [26:0] ms;
        logic        sw;
        int          lat;
        int          acc;
        bit          seen;
    } exp_t;

    exp_t        q[$];
    int          n_cmp = 0;
    int          n_err = 0;
    int          cyc = 0;
    bit          expect_low = 0;
    logic [7:0]  last_e;
    logic [23:0] last_mb;
    logic [26:0] last_ms;
    logic        last_sw;
    int          last_lat;

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout");
        $fatal(1, "simulation time limit");
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, req);
        end
    endtask

    // Exact alignment: one full right shift of {mant,000} by diff, sticky = any lost bit.
    function automatic exp_t model(input logic [7:0] ea, input logic [23:0] ma,
                                   input logic [7:0] eb, input logic [23:0] mb);
        exp_t r;
        bit a_big;
        int diff;
        longint unsigned sm;
        longint unsigned lost;
        a_big = (ea > eb) || (ea == eb && ma >= mb);
        diff  = a_big ? int'(ea) - int'(eb) : int'(eb) - int'(ea);
        r.e   = a_big ? ea : eb;
        r.mb  = a_big ? ma : mb;
        r.sw  = !a_big;
        sm    = longint'(a_big ? mb : ma) << 3;
        if (diff >= 27) begin
            r.ms = (sm != 0) ? 27'd1 : 27'd0;
        end else begin
            lost = sm & ((64'd1 << diff) - 1);
            r.ms = 27'((sm >> diff) | ((lost != 0) ? 1 : 0));
        end
        r.lat  = (diff == 0 || diff >= 27) ? 1 : 1 + (diff + 3) / 4;
        r.acc  = 0;
        r.seen = 0;
        return r;
    endfunction

    // Result monitor: checks every cycle out_valid is high against the queue head.
    initial forever begin
        @(negedge clk);
        if (rst_n) begin
            if (expect_low) begin
                chk("valid_after_handshake", bus.out_valid, 0);
                chk("ready_after_handshake", bus.in_ready, 1);
                expect_low = 0;
            end
            if (bus.out_valid) begin
                if (q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL spurious_result: got out_valid=1, expected 0 (exp_out=%0h)",
                             bus.exp_out);
                end else begin
                    chk("exp_out", bus.exp_out, q[0].e);
                    chk("mant_big", bus.mant_big, q[0].mb);
                    chk("mant_small", bus.mant_small, q[0].ms);
                    chk("swapped", bus.swapped, q[0].sw);
                    chk("in_ready_in_done", bus.in_ready, 0);
                    if (!q[0].seen) begin
                        last_lat = cyc - q[0].acc;
                        chk("latency", last_lat, q[0].lat);
                        q[0].seen = 1;
                    end
                    if (bus.out_ready) begin
                        last_e  = bus.exp_out;
                        last_mb = bus.mant_big;
                        last_ms = bus.mant_small;
                        last_sw = bus.swapped;
                        void'(q.pop_front());
                        expect_low = 1;
                    end
                end
            end
        end
    end

    task automatic send(input logic [7:0] ea, input logic [23:0] ma,
                        input logic [7:0] eb, input logic [23:0] mb);
        exp_t e;
        int   n = 0;
        @(negedge clk);
        while (!bus.in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!bus.in_ready) begin
            n_cmp++;
            n_err++;
            $display("FAIL send_timeout: got in_ready=0, expected 1");
            return;
        end
        bus.in_valid = 1;
        bus.exp_a    = ea;
        bus.mant_a   = ma;
        bus.exp_b    = eb;
        bus.mant_b   = mb;
        e = model(ea, ma, eb, mb);
        e.acc = cyc + 1;
        q.push_back(e);
        @(posedge clk);
        #1 bus.in_valid = 0;
    endtask

    task automatic wait_done();
        int n = 0;
        while (q.size() != 0 && n < 300) begin
            @(posedge clk);
            #2;
            n++;
        end
        if (q.size() != 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL result_timeout: got %0d pending, expected 0", q.size());
            q.delete();
        end
    endtask

    initial begin
        exp_t m;
        int   n;
        rst_n         = 0;
        bus.in_valid  = 0;
        bus.exp_a     = 0;
        bus.mant_a    = 0;
        bus.exp_b     = 0;
        bus.mant_b    = 0;
        bus.out_ready = 1;

        // Pin the model against hand-worked cases.
        m = model(8'h7B, 24'h800001, 8'h80, 24'h900000);
        chk("model_t2_ms", m.ms, 27'h200001);
        chk("model_t2_lat", m.lat, 3);
        m = model(8'h8A, 24'h800000, 8'h70, 24'h800000);
        chk("model_d26_lat", m.lat, 8);
        chk("model_d26_ms", m.ms, 27'h1);
        m = model(8'h9B, 24'h800000, 8'h80, 24'h000000);
        chk("model_d27_zero_ms", m.ms, 27'h0);

        repeat (3) @(negedge clk);
        chk("rst_in_ready", bus.in_ready, 1);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_exp_out", bus.exp_out, 0);
        chk("rst_mant_big", bus.mant_big, 0);
        chk("rst_mant_small", bus.mant_small, 0);
        chk("rst_swapped", bus.swapped, 0);
        rst_n = 1;

        // Equal exponents.
        send(8'h80, 24'hC00000, 8'h80, 24'hA00000);
        wait_done();
        chk("t1_lat", last_lat, 1);
        chk("t1_mant_small", last_ms, 27'h5000000);
        chk("t1_swapped", last_sw, 0);

        // Swap with sticky.
        send(8'h7B, 24'h800001, 8'h80, 24'h900000);
        wait_done();
        chk("t2_lat", last_lat, 3);
        chk("t2_swapped", last_sw, 1);
        chk("t2_mant_big", last_mb, 24'h900000);
        chk("t2_mant_small", last_ms, 27'h200001);

        // Large differences: 32 short-circuits, 26 iterates.
        send(8'h90, 24'h800000, 8'h70, 24'h800000);
        wait_done();
        chk("t3a_lat", last_lat, 1);
        chk("t3a_mant_small", last_ms, 27'h1);
        send(8'h8A, 24'h800000, 8'h70, 24'h800000);
        wait_done();
        chk("t3b_lat", last_lat, 8);
        chk("t3b_mant_small", last_ms, 27'h1);

        // Equal exponents, B larger by mantissa.
        send(8'h40, 24'h800000, 8'h40, 24'h800001);
        wait_done();
        chk("t6_swapped", last_sw, 1);
        chk("t6_mant_big", last_mb, 24'h800001);
        chk("t6_mant_small", last_ms, 27'h4000000);

        // Boundaries checked through the model only.
        send(8'h84, 24'hABCDEF, 8'h80, 24'h123457);
        send(8'h80, 24'h000001, 8'h81, 24'hFFFFFF);
        send(8'h9B, 24'h800000, 8'h80, 24'h800000);
        send(8'h80, 24'h800000, 8'h9A, 24'h000000);
        send(8'h80, 24'h000000, 8'h80, 24'h000000);
        send(8'h00, 24'h000003, 8'hFF, 24'h7FFFFF);
        send(8'h83, 24'h555555, 8'h80, 24'hFFFFFF);
        wait_done();

        // Backpressure: hold DONE, pulse in_valid meanwhile.
        bus.out_ready = 0;
        send(8'h88, 24'hFFFFFF, 8'h80, 24'hF0F0F1);
        n = 0;
        while (!bus.out_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("bp_out_valid_seen", bus.out_valid, 1);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (i == 1) begin
                bus.in_valid = 1;
                bus.exp_a    = 8'h10;
                bus.mant_a   = 24'h123456;
                bus.exp_b    = 8'h20;
                bus.mant_b   = 24'h654321;
            end
            if (i == 3) bus.in_valid = 0;
            chk("bp_in_ready", bus.in_ready, 0);
            chk("bp_out_valid", bus.out_valid, 1);
        end
        @(posedge clk);
        #1 bus.out_ready = 1;
        wait_done();
        repeat (10) @(negedge clk);

        // Reset in the middle of SHIFT (diff 20).
        send(8'h80, 24'h800000, 8'h6C, 24'hFFFFFF);
        repeat (3) @(posedge clk);
        #3 rst_n = 0;
        #1;
        chk("mid_rst_in_ready", bus.in_ready, 1);
        chk("mid_rst_out_valid", bus.out_valid, 0);
        chk("mid_rst_exp_out", bus.exp_out, 0);
        chk("mid_rst_mant_big", bus.mant_big, 0);
        chk("mid_rst_mant_small", bus.mant_small, 0);
        chk("mid_rst_swapped", bus.swapped, 0);
        q.delete();
        expect_low = 0;
        repeat (2) @(negedge clk);
        rst_n = 1;
        repeat (15) @(negedge clk);
        chk("post_rst_out_valid", bus.out_valid, 0);

        // Recovery after reset.
        send(8'h7B, 24'h800001, 8'h80, 24'h900000);
        wait_done();
        chk("recover_mant_small", last_ms, 27'h200001);
        repeat (3) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
